// File: rtl/game_state_fsm.sv
// Game-flow controller for the shoot-'em-up: cover -> play -> success / game-over,
// with life and bomb bookkeeping and a timed invulnerability window.
module game_state_fsm #(
    parameter int unsigned INIT_LIFE     = 3,
    parameter int unsigned INIT_BOMB     = 3,
    parameter int unsigned INVULN_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       hard_reset,
    input  logic       enter,
    input  logic       bomb,
    input  logic       collision,
    input  logic       die,
    output logic [3:0] num_life,
    output logic [3:0] num_bomb,
    output logic [3:0] game_state,
    output logic       game_en,
    output logic       game_reset
);

    typedef enum logic [3:0] {
        StCover    = 4'b0001,
        StPlay     = 4'b0010,
        StInvuln   = 4'b0100,
        StSuccess  = 4'b1000,
        StGameover = 4'b1001
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  life_q, life_d;
    logic [3:0]  bomb_cnt_q, bomb_cnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic        enter_q, bomb_q;
    logic        game_en_q, game_en_d;
    logic        game_reset_q, game_reset_d;
    logic        enter_rise, bomb_rise;

    assign enter_rise = enter & ~enter_q;
    assign bomb_rise  = bomb & ~bomb_q;

    always_comb begin
        state_d    = state_q;
        life_d     = life_q;
        bomb_cnt_d = bomb_cnt_q;
        cnt_d      = cnt_q;

        case (state_q)
            StCover: begin
                if (enter_rise) begin
                    state_d    = StPlay;
                    life_d     = 4'(INIT_LIFE);
                    bomb_cnt_d = 4'(INIT_BOMB);
                    cnt_d      = '0;
                end
            end
            StPlay: begin
                if (die) begin
                    state_d = StSuccess;
                end else if (collision) begin
                    // A hit on the last life ends the game; never underflow.
                    if (life_q <= 4'd1) begin
                        life_d  = 4'd0;
                        state_d = StGameover;
                    end else begin
                        life_d  = life_q - 4'd1;
                        cnt_d   = '0;
                        state_d = StInvuln;
                    end
                end else if (bomb_rise && (bomb_cnt_q != 4'd0)) begin
                    bomb_cnt_d = bomb_cnt_q - 4'd1;
                    cnt_d      = '0;
                    state_d    = StInvuln;
                end
            end
            StInvuln: begin
                if (die) begin
                    state_d = StSuccess;
                end else if (cnt_q == 32'(INVULN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StSuccess, StGameover: begin
                if (enter_rise) begin
                    state_d = StCover;
                end
            end
            default: state_d = StCover;
        endcase

        // Outputs are registered, so decode from the state being entered.
        game_en_d    = (state_d == StPlay) || (state_d == StInvuln);
        game_reset_d = !game_en_d;
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q      <= StCover;
            life_q       <= 4'(INIT_LIFE);
            bomb_cnt_q   <= 4'(INIT_BOMB);
            cnt_q        <= '0;
            enter_q      <= 1'b0;
            bomb_q       <= 1'b0;
            game_en_q    <= 1'b0;
            game_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            life_q       <= life_d;
            bomb_cnt_q   <= bomb_cnt_d;
            cnt_q        <= cnt_d;
            enter_q      <= enter;
            bomb_q       <= bomb;
            game_en_q    <= game_en_d;
            game_reset_q <= game_reset_d;
        end
    end

    assign game_state = state_q;
    assign num_life   = life_q;
    assign num_bomb   = bomb_cnt_q;
    assign game_en    = game_en_q;
    assign game_reset = game_reset_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed + random bench for game_state_fsm against a mode/countdown reference model.
module tb_game_state_fsm;

    localparam int unsigned NL = 3;
    localparam int unsigned NB = 3;
    localparam int unsigned NI = 4;

    localparam int MCover = 0, MPlay = 1, MInvuln = 2, MSuccess = 3, MOver = 4;

    logic       clk = 1'b0;
    logic       hard_reset = 1'b0;
    logic       enter = 1'b0, bomb = 1'b0, collision = 1'b0, die = 1'b0;
    logic [3:0] num_life, num_bomb, game_state;
    logic       game_en, game_reset;

    int errors = 0;
    int checks = 0;

    // Reference model: game mode, counts, remaining protected cycles, last key levels.
    int m_mode, m_life, m_bomb, m_left;
    bit m_prev_enter, m_prev_bomb;

    always #5 clk = ~clk;

    game_state_fsm #(
        .INIT_LIFE    (NL),
        .INIT_BOMB    (NB),
        .INVULN_CYCLES(NI)
    ) dut (
        .clk       (clk),
        .hard_reset(hard_reset),
        .enter     (enter),
        .bomb      (bomb),
        .collision (collision),
        .die       (die),
        .num_life  (num_life),
        .num_bomb  (num_bomb),
        .game_state(game_state),
        .game_en   (game_en),
        .game_reset(game_reset)
    );

    function automatic logic [3:0] mode_code(input int mode);
        case (mode)
            MCover:   return 4'b0001;
            MPlay:    return 4'b0010;
            MInvuln:  return 4'b0100;
            MSuccess: return 4'b1000;
            default:  return 4'b1001;
        endcase
    endfunction

    task automatic model_step();
        bit er, br;
        if (hard_reset) begin
            m_mode = MCover; m_life = NL; m_bomb = NB; m_left = 0;
            m_prev_enter = 1'b0; m_prev_bomb = 1'b0;
            return;
        end
        er = enter && !m_prev_enter;
        br = bomb && !m_prev_bomb;
        m_prev_enter = enter;
        m_prev_bomb  = bomb;
        case (m_mode)
            MCover: if (er) begin
                m_mode = MPlay; m_life = NL; m_bomb = NB;
            end
            MPlay: begin
                if (die) m_mode = MSuccess;
                else if (collision) begin
                    m_life = (m_life > 0) ? m_life - 1 : 0;
                    if (m_life == 0) m_mode = MOver;
                    else begin m_mode = MInvuln; m_left = NI; end
                end else if (br && m_bomb > 0) begin
                    m_bomb = m_bomb - 1; m_mode = MInvuln; m_left = NI;
                end
            end
            MInvuln: begin
                if (die) m_mode = MSuccess;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = MPlay;
                end
            end
            default: if (er) m_mode = MCover;
        endcase
    endtask

    task automatic check_model();
        logic       exp_en;
        exp_en = (m_mode == MPlay) || (m_mode == MInvuln);
        checks++;
        assert (game_state === mode_code(m_mode)) else begin
            errors++;
            $error("FAIL state obs=%b exp=%b", game_state, mode_code(m_mode));
        end
        checks++;
        assert (num_life === 4'(m_life)) else begin
            errors++;
            $error("FAIL life obs=%0d exp=%0d", num_life, m_life);
        end
        checks++;
        assert (num_bomb === 4'(m_bomb)) else begin
            errors++;
            $error("FAIL bomb obs=%0d exp=%0d", num_bomb, m_bomb);
        end
        checks++;
        assert (game_en === exp_en) else begin
            errors++;
            $error("FAIL game_en obs=%b exp=%b", game_en, exp_en);
        end
        checks++;
        assert (game_reset === !exp_en) else begin
            errors++;
            $error("FAIL game_reset obs=%b exp=%b", game_reset, !exp_en);
        end
    endtask

    // Fixed-value spot checks at the test plan's milestones.
    task automatic check_const(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ent, input bit bmb, input bit col, input bit dth,
                        input int n = 1);
        for (int i = 0; i < n; i++) begin
            hard_reset = rst; enter = ent; bomb = bmb; collision = col; die = dth;
            @(posedge clk);
            model_step();
            #1;
            check_model();
        end
    endtask

    initial begin
        m_mode = MCover; m_life = NL; m_bomb = NB; m_left = 0;
        m_prev_enter = 1'b0; m_prev_bomb = 1'b0;
        #1;

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2);
        check_const("reset_state", game_state, 4'b0001);

        step(0, 1, 0, 0, 0);
        check_const("enter_play", game_state, 4'b0010);
        step(0, 1, 0, 0, 0, 9);
        check_const("enter_held", game_state, 4'b0010);
        step(0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 0);
        check_const("hit_invuln", game_state, 4'b0100);
        check_const("hit_life", num_life, 4'd2);
        step(0, 0, 0, 1, 0, 3);
        check_const("held_hit_life", num_life, 4'd2);
        step(0, 0, 0, 0, 0);
        check_const("window_end", game_state, 4'b0010);

        step(0, 0, 1, 1, 0);
        check_const("bomb_col_life", num_life, 4'd1);
        check_const("bomb_col_bomb", num_bomb, 4'd3);
        step(0, 0, 0, 0, 0, 5);

        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 5);
        end
        check_const("bombs_empty", num_bomb, 4'd0);
        check_const("bombs_play", game_state, 4'b0010);

        step(0, 0, 0, 1, 0);
        check_const("gameover", game_state, 4'b1001);
        check_const("gameover_life", num_life, 4'd0);
        step(0, 1, 0, 0, 0);
        check_const("over_to_cover", game_state, 4'b0001);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 1);
        check_const("die_success", game_state, 4'b1000);
        check_const("die_life", num_life, 4'd3);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 2);
        step(1, 0, 0, 0, 0);
        check_const("rst_invuln", game_state, 4'b0001);
        check_const("rst_life", num_life, 4'd3);

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
